// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use stall and registered ALU forwarding selects for the 5-stage pipeline
// Ports: clk/rst_n (async active-low); id_* decode-stage instruction fields; flush squashes ID;
// stall holds PC and IF/ID and bubbles EX; fwd_a/fwd_b are the EX operand selects (00 regfile, 10 EX/MEM, 01 MEM/WB);
// ex_dest/mem_dest/wb_dest and wb_reg_write expose the shadow pipeline; stall_count counts stall
// cycles when HAZARD_STALL_STATS_EN is defined and is tied to 0 otherwise.
module hazard_scoreboard #(
  parameter int AW = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [AW-1:0]    ex_dest,
  output logic [AW-1:0]    mem_dest,
  output logic [AW-1:0]    wb_dest,
  output logic             wb_reg_write,
  output logic [CNT_W-1:0] stall_count
);
  logic [AW-1:0] id_dest;
  logic id_we, bubble, ex_we, ex_ld, mem_we;
  logic [1:0] sel_a, sel_b;
  assign id_dest = id_reg_dst ? id_rd : id_rt;
  assign id_we = id_valid & id_reg_write & (id_dest != '0);
  assign stall = ex_ld & ex_we & ((id_use_rs & (id_rs == ex_dest)) | (id_use_rt & (id_rt == ex_dest))) & id_valid & ~flush;
  assign bubble = ~id_valid | flush | stall;
  // a load still in EX cannot feed EX/MEM, so only non-loads forward from there
  function automatic logic [1:0] fsel(input logic use_r, input logic [AW-1:0] r);
    return (use_r & ex_we & ~ex_ld & (r == ex_dest)) ? 2'b10 :
           (use_r & mem_we & (r == mem_dest)) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    sel_a = fsel(id_use_rs, id_rs);
    sel_b = fsel(id_use_rt, id_rt);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_we <= 1'b0;
      ex_ld <= 1'b0;
      ex_dest <= '0;
      mem_we <= 1'b0;
      mem_dest <= '0;
      wb_reg_write <= 1'b0;
      wb_dest <= '0;
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else begin
      wb_reg_write <= mem_we;
      wb_dest <= mem_dest;
      mem_we <= ex_we;
      mem_dest <= ex_dest;
      ex_we <= ~bubble & id_we;
      ex_ld <= ~bubble & id_mem_read;
      ex_dest <= bubble ? '0 : id_dest;
      fwd_a <= bubble ? 2'b00 : sel_a;
      fwd_b <= bubble ? 2'b00 : sel_b;
    end
  end
`ifdef HAZARD_STALL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count <= '0;
    else if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
  end
`else
  assign stall_count = '0;
`endif
endmodule
